// File: rtl/pulse_window_pkg.sv
// Shared types and defaults for the pulse window counter and its helpers.
package pulse_window_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int WIN_DEF = 16;
    localparam int CW_DEF  = 8;

endpackage

// File: rtl/pulse_window_counter_rise_det.sv
// Rising-edge detector: one history flop and an AND gate.
module rise_det (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) prev_q <= 1'b0;
        else       prev_q <= d;
    end

    assign rise = d & ~prev_q;

endmodule

// File: rtl/pulse_window_counter.sv
// Counts rising edges of y_in over back-to-back WIN-cycle windows and
// hands each window's count to a consumer over valid/ready.
module pulse_window_counter
    import pulse_window_pkg::*;
#(
    parameter int WIN = WIN_DEF,
    parameter int CW  = CW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic          y_in,
    output logic [CW-1:0] cnt_out,
    output logic          sat,
    output logic          cnt_valid,
    input  logic          cnt_ready,
    output logic          overrun
);

    localparam int WW = $clog2(WIN);
    localparam logic [WW-1:0] LAST = WW'(WIN - 1);

    state_e        state_q, state_d;
    logic [WW-1:0] win_q, win_d;
    logic [CW-1:0] ev_q, ev_d;
    logic          evsat_q, evsat_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sat_q, sat_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;

    logic          rise;
    logic          run;
    logic          close;
    logic          ev_max;
    logic [CW-1:0] ev_next;
    logic          sat_next;
    logic          accept;

    rise_det u_rise (
        .clk  (clk),
        .rstn (rstn),
        .d    (y_in),
        .rise (rise)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (en)  state_d = RUN;
            RUN:  if (!en) state_d = IDLE;
            default:       state_d = IDLE;
        endcase
    end

    always_comb begin
        run   = (state_q == RUN);
        close = run && (win_q == LAST);
    end

    // Final count folds in this cycle's edge so a close-cycle edge is kept.
    always_comb begin
        ev_max   = &ev_q;
        ev_next  = (rise && !ev_max) ? ev_q + 1'b1 : ev_q;
        sat_next = evsat_q | (rise & ev_max);
    end

    always_comb begin
        win_d   = '0;
        ev_d    = '0;
        evsat_d = 1'b0;
        if (run && en && !close) begin
            win_d   = win_q + 1'b1;
            ev_d    = ev_next;
            evsat_d = sat_next;
        end
    end

    always_comb begin
        accept  = valid_q & cnt_ready;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (close) begin
            if (!valid_q || accept) begin
                cnt_d   = ev_next;
                sat_d   = sat_next;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_q   <= '0;
            ev_q    <= '0;
            evsat_q <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            win_q   <= win_d;
            ev_q    <= ev_d;
            evsat_q <= evsat_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign cnt_out   = cnt_q;
    assign sat       = sat_q;
    assign cnt_valid = valid_q;
    assign overrun   = ovr_q;

endmodule

// File: doc/pulse_window_counter.md
# pulse_window_counter

Downstream consumer of the single-bit Moore FSM output stream (`y_out`) in the sequential-circuit exercise set. The block counts rising edges of that stream over fixed back-to-back windows of `WIN` clock cycles. It presents each window's count to a consumer over a valid/ready handshake, with saturation and overrun reporting. Together with the FSM it forms a self-checking chain: a pulse rate measured here can be compared against the expected rate for a given `x_in` pattern.

## Interface
- `WIN`, 16, cycles per counting window; legal range ≥ 2.
- `CW`, 8, width of the count result.

- `clk`  input  1  single clock; all state updates on rising edge.
- `rstn`  input  1  asynchronous active-low reset.
- `en`  input  1  counting enable; high = run windows, low = idle.
- `y_in`  input  1  pulse stream, connected to the upstream FSM `y_out`.
- `cnt_out`  output  CW  event count of the last completed window.
- `sat`  output  1  the result in `cnt_out` saturated; qualified by `cnt_valid`.
- `cnt_valid`  output  1  `cnt_out`/`sat` hold an unconsumed result.
- `cnt_ready`  input  1  consumer accepts the result when high together with `cnt_valid`.
- `overrun`  output  1  sticky: a completed window's result was dropped.

## Operation
- **Reset.** `rstn` low asynchronously forces:
  - state IDLE, window counter 0, event counter 0, `y_prev` 0;
  - `cnt_out` 0, `sat` 0, `cnt_valid` 0, `overrun` 0.
- **Edge detect.**
  - `y_prev` samples `y_in` every cycle, in every state.
  - A cycle is an edge when `y_in & ~y_prev`.
- **IDLE.** Window and event counters are held at 0. When `en` is sampled high, go to RUN with window counter 0.
- **RUN.**
  - The window counter increments every cycle, 0 to `WIN-1`.
  - Each edge cycle increments the event counter, which saturates at 2^CW−1.
  - A saturation flag is set when an increment is requested at max.
- **Window close.** This is the cycle with window counter = `WIN-1`.
  - The final count (event counter plus that cycle's edge, saturating) and the final saturation flag form the result.
  - The window counter, event counter and saturation flag restart at 0 on the next cycle. There is no gap between windows.
- **Result load.**
  - If `cnt_valid` is 0, or `cnt_valid & cnt_ready` in the close cycle: load the result and set `cnt_valid` to 1.
  - Otherwise: drop the result and set `overrun` to 1.
- **Handshake.**
  - `cnt_out` and `sat` are stable while `cnt_valid` is high.
  - `cnt_valid` clears on a `cnt_valid & cnt_ready` cycle, unless a new result loads in that same cycle.
- **`en` low in RUN.**
  - Go to IDLE on the next edge and discard the partial window.
  - If the `en`-low cycle is itself a close cycle, that window completes normally.
  - A pending result stays valid until accepted.
- **Throughput bound.** The upstream FSM never holds S1 for two cycles, so edges arrive at most once every 2 cycles. Expect at most ⌈WIN/2⌉ edges per window. Saturation is therefore reachable only when 2^CW−1 < ⌈WIN/2⌉.

## Timing
- The first RUN cycle is the cycle after `en` is sampled high. A window spans `WIN` RUN cycles.
- `cnt_valid` rises on the clock edge ending the close cycle, i.e. 1 cycle after the close cycle.
- Edge-to-report latency is between 1 and `WIN` cycles.
- An edge on the close cycle counts in the closing window, not the next one.
- An edge on the first RUN cycle counts. A level already high when RUN starts counts only if `y_prev` was 0 in that cycle.
- A reset mid-window takes effect immediately. There is no partial report, and `overrun` is cleared.

## Structure
- Shared package `pulse_window_pkg`:
  - state encoding `IDLE`/`RUN` (1 bit);
  - default `WIN` and `CW` constants.
- One natural sub-module, `rise_det`: `clk`, `rstn`, `d` → `rise`. It holds the `y_prev` flop and the AND gate, and is reusable by other exercise benches.
- The top holds the FSM, the window counter (width clog2(WIN)), the saturating event counter and the output/handshake registers.

## Test plan
All scenarios use `WIN`=16, `CW`=8 unless stated.

- **Reset.** Assert `rstn` low mid-window with `cnt_valid`=1 and `overrun`=1.
  - Required: all outputs 0 immediately (asynchronous). After `rstn` is released with `en`=1, counting restarts at window counter 0.
- **Basic count.** Drive `en`=1 and `cnt_ready`=1, with 1-cycle `y_in` pulses on RUN cycles 2, 5 and 15.
  - Required: `cnt_valid`=1 one cycle after RUN cycle 15, with `cnt_out`=3 and `sat`=0.
  - Required: the next window with no pulses reports `cnt_out`=0.
- **Level versus edge.** Raise `y_in` on RUN cycle 3 and hold it high for 20 cycles.
  - Required: window 1 reports 1; window 2 reports 0.
- **Backpressure.** Drive `cnt_ready`=0 for 2 full windows, with 4 pulses in window 1 and 6 in window 2.
  - Required: `cnt_out` holds 4, `overrun`=1 after the second close, and `overrun` stays 1 after `cnt_ready` returns to 1.
- **Coincident accept and close.** Pulse `cnt_ready` exactly in the close cycle, with 2 pulses in the new window and `cnt_valid` already 1.
  - Required: `cnt_valid` stays 1, `cnt_out` updates to 2, `overrun`=0.
- **Saturation.** Use `CW`=2 with 8 pulses spaced 2 cycles apart.
  - Required: `cnt_out`=3, `sat`=1. The next window with 1 pulse reports `cnt_out`=1, `sat`=0.
